// File: rtl/light_conflict_monitor.sv
// Safety monitor between the traffic light controller and the lamp drivers.
// Registers the controller codes onto the lamps and latches a flashing-red fault on any unsafe pattern.
module light_conflict_monitor #(
  parameter int MIN_YELLOW     = 3,
  parameter int STARTUP_CYCLES = 5,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  input  logic       clear_fault,
  output logic [2:0] lamp_M1,
  output logic [2:0] lamp_M2,
  output logic [2:0] lamp_MT,
  output logic [2:0] lamp_S,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [CNT_W-1:0] MIN_Y  = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(STARTUP_CYCLES - 1);

  typedef enum logic [1:0] {STARTUP, NORMAL, FAULT, RECOVER} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] scnt, scnt_next;
  logic             flash, flash_next;
  logic             fault_next;
  logic [2:0]       code_next;
  logic [2:0]       viol;
  logic [2:0]       cur       [4];
  logic [2:0]       prev      [4];
  logic [CNT_W-1:0] ycnt      [4];
  logic [2:0]       lamp      [4];
  logic [2:0]       lamp_next [4];
  logic             inv, conflict, skip, short_y, do_check;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic lit(input logic [2:0] c);
    return (c == GRN) || (c == YEL);
  endfunction

  // Index order 0..3 = M1, M2, MT, S
  assign cur[0] = light_M1;
  assign cur[1] = light_M2;
  assign cur[2] = light_MT;
  assign cur[3] = light_S;

  assign lamp_M1 = lamp[0];
  assign lamp_M2 = lamp[1];
  assign lamp_MT = lamp[2];
  assign lamp_S  = lamp[3];

  always_comb begin
    inv     = 1'b0;
    skip    = 1'b0;
    short_y = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cur[i] != RED && cur[i] != YEL && cur[i] != GRN) inv = 1'b1;
      if (prev[i] == GRN && cur[i] == RED) skip = 1'b1;
      // ycnt still holds the yellow run length before this red sample
      if (prev[i] == YEL && cur[i] == RED && ycnt[i] < MIN_Y) short_y = 1'b1;
    end
    conflict = (lit(cur[3]) && (lit(cur[0]) || lit(cur[1]) || lit(cur[2]))) ||
               (cur[2] == GRN && lit(cur[1]));
    if (inv)           viol = 3'd1;
    else if (conflict) viol = 3'd2;
    else if (skip)     viol = 3'd3;
    else if (short_y)  viol = 3'd4;
    else               viol = 3'd0;
  end

  always_comb begin
    state_next = state;
    scnt_next  = scnt;
    flash_next = 1'b1;
    fault_next = fault;
    code_next  = fault_code;
    do_check   = 1'b0;
    for (int i = 0; i < 4; i++) lamp_next[i] = RED;
    case (state)
      STARTUP: begin
        if (scnt == S_LAST) begin
          state_next = NORMAL;
          scnt_next  = '0;
        end else begin
          scnt_next = scnt + 1'b1;
        end
      end
      NORMAL: do_check = 1'b1;
      FAULT: begin
        if (clear_fault) begin
          state_next = RECOVER;
          scnt_next  = '0;
        end else begin
          flash_next = ~flash;
          for (int i = 0; i < 4; i++) lamp_next[i] = {~flash, 2'b00};
        end
      end
      RECOVER: begin
        if (scnt == S_LAST) begin
          scnt_next = '0;
          do_check  = 1'b1;
        end else begin
          scnt_next = scnt + 1'b1;
        end
      end
      default: state_next = STARTUP;
    endcase
    if (do_check) begin
      if (viol != 3'd0) begin
        state_next = FAULT;
        fault_next = 1'b1;
        code_next  = viol;
      end else begin
        state_next = NORMAL;
        fault_next = 1'b0;
        code_next  = 3'd0;
        for (int i = 0; i < 4; i++) lamp_next[i] = cur[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= STARTUP;
      scnt       <= '0;
      flash      <= 1'b1;
      fault      <= 1'b0;
      fault_code <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        lamp[i] <= RED;
        prev[i] <= RED;
        ycnt[i] <= '0;
      end
    end else begin
      state      <= state_next;
      scnt       <= scnt_next;
      flash      <= flash_next;
      fault      <= fault_next;
      fault_code <= code_next;
      for (int i = 0; i < 4; i++) begin
        lamp[i] <= lamp_next[i];
        prev[i] <= cur[i];
        ycnt[i] <= (cur[i] == YEL) ? sat_inc(ycnt[i]) : '0;
      end
    end
  end

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Bench for light_conflict_monitor: directed scenarios then random codes,
// compared each cycle against a rule-level model of the intersection safety checks.
module tb_light_conflict_monitor;

  localparam int MIN_YELLOW     = 3;
  localparam int STARTUP_CYCLES = 5;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic       clear_fault;
  logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
  logic       fault;
  logic [2:0] fault_code;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 startup, 1 normal, 2 fault, 3 recover
  int         m_mode;
  int         m_timer;
  int         m_run   [4];
  logic [2:0] m_prev  [4];
  logic [2:0] m_lamp  [4];
  logic [2:0] in_c    [4];
  logic       m_fault;
  logic [2:0] m_code;
  logic       m_red_on;

  light_conflict_monitor #(.MIN_YELLOW(MIN_YELLOW), .STARTUP_CYCLES(STARTUP_CYCLES), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
    .clear_fault(clear_fault),
    .lamp_M1(lamp_M1), .lamp_M2(lamp_M2), .lamp_MT(lamp_MT), .lamp_S(lamp_S),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  function automatic logic showing(input logic [2:0] c);
    return (c == GRN) || (c == YEL);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_timer = 0; m_fault = 1'b0; m_code = 3'd0; m_red_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0; m_prev[i] = RED; m_lamp[i] = RED;
    end
  endtask

  function automatic logic [2:0] judge();
    logic bad, clash, skipped, short_y;
    bad = 0; skipped = 0; short_y = 0;
    for (int i = 0; i < 4; i++) begin
      if (!(in_c[i] inside {RED, YEL, GRN})) bad = 1;
      if (m_prev[i] == GRN && in_c[i] == RED) skipped = 1;
      if (m_prev[i] == YEL && in_c[i] == RED && m_run[i] < MIN_YELLOW) short_y = 1;
    end
    clash = (showing(in_c[3]) && (showing(in_c[0]) || showing(in_c[1]) || showing(in_c[2]))) ||
            (in_c[2] == GRN && showing(in_c[1]));
    if (bad) return 3'd1;
    if (clash) return 3'd2;
    if (skipped) return 3'd3;
    if (short_y) return 3'd4;
    return 3'd0;
  endfunction

  task automatic all_red();
    for (int i = 0; i < 4; i++) m_lamp[i] = RED;
  endtask

  task automatic apply_normal(input logic [2:0] v);
    if (v != 0) begin
      m_mode = 2; m_fault = 1'b1; m_code = v; m_red_on = 1'b1; all_red();
    end else begin
      m_mode = 1; m_fault = 1'b0; m_code = 3'd0;
      for (int i = 0; i < 4; i++) m_lamp[i] = in_c[i];
    end
  endtask

  task automatic model_edge();
    logic [2:0] v;
    if (!rst) begin
      model_reset();
      return;
    end
    in_c[0] = light_M1; in_c[1] = light_M2; in_c[2] = light_MT; in_c[3] = light_S;
    v = judge();
    case (m_mode)
      0: begin
        all_red();
        m_timer++;
        if (m_timer == STARTUP_CYCLES) begin m_mode = 1; m_timer = 0; end
      end
      1: apply_normal(v);
      2: begin
        if (clear_fault) begin
          m_mode = 3; m_timer = 0; m_red_on = 1'b1; all_red();
        end else begin
          m_red_on = !m_red_on;
          for (int i = 0; i < 4; i++) m_lamp[i] = {m_red_on, 2'b00};
        end
      end
      default: begin
        m_timer++;
        if (m_timer == STARTUP_CYCLES) begin m_timer = 0; apply_normal(v); end
        else all_red();
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      m_run[i]  = (in_c[i] == YEL) ? m_run[i] + 1 : 0;
      m_prev[i] = in_c[i];
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("lamp_M1", lamp_M1, m_lamp[0]);
    chk("lamp_M2", lamp_M2, m_lamp[1]);
    chk("lamp_MT", lamp_MT, m_lamp[2]);
    chk("lamp_S", lamp_S, m_lamp[3]);
    chk("fault", {2'b00, fault}, {2'b00, m_fault});
    chk("fault_code", fault_code, m_code);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input logic [2:0] m1, input logic [2:0] m2,
                        input logic [2:0] mt, input logic [2:0] s);
    light_M1 = m1; light_M2 = m2; light_MT = mt; light_S = s;
  endtask

  task automatic recover_all_red();
    set_in(RED, RED, RED, RED);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    repeat (STARTUP_CYCLES) tick();
  endtask

  task automatic restart();
    #2 rst = 1'b0;
    #1 model_reset();
    tick();
    #2 rst = 1'b1;
    set_in(RED, RED, RED, RED);
    repeat (STARTUP_CYCLES) tick();
  endtask

  logic [2:0] m1_seq [6];
  logic [2:0] bad_codes [5];
  logic [2:0] rnd [4];

  initial begin
    m1_seq = '{GRN, GRN, YEL, YEL, YEL, RED};
    bad_codes = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    rst = 1'b1; clear_fault = 1'b0;
    set_in(RED, RED, RED, RED);
    model_reset();
    #1 rst = 1'b0;
    #1 check_all();
    repeat (2) tick();
    #2 rst = 1'b1;
    repeat (STARTUP_CYCLES) tick();

    // Legal main-road sequence passes through with one cycle of latency
    for (int k = 0; k < 6; k++) begin
      light_M1 = m1_seq[k];
      tick();
    end
    tick();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;

    // Short yellow on M2, then flashing red
    foreach (m1_seq[k]) if (k < 1) light_M2 = GRN;
    tick();
    light_M2 = YEL; tick();
    tick();
    light_M2 = RED; tick();
    repeat (4) tick();
    recover_all_red();

    // Invalid beats conflict, then plain conflict
    set_in(GRN, RED, 3'b011, GRN); tick();
    tick();
    recover_all_red();
    set_in(GRN, RED, RED, GRN); tick();
    tick();
    recover_all_red();

    // Skipped yellow on the turn lane
    light_MT = GRN; tick();
    light_MT = RED; tick();
    tick();
    recover_all_red();

    // Random codes with sticky approaches and sporadic clears
    for (int n = 0; n < 400; n++) begin
      rnd[0] = light_M1; rnd[1] = light_M2; rnd[2] = light_MT; rnd[3] = light_S;
      for (int i = 0; i < 4; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 3) rnd[i] = bad_codes[$urandom_range(0, 4)];
        else if (r < 25) begin
          case ($urandom_range(0, 2))
            0: rnd[i] = RED;
            1: rnd[i] = YEL;
            default: rnd[i] = GRN;
          endcase
        end
      end
      set_in(rnd[0], rnd[1], rnd[2], rnd[3]);
      clear_fault = ($urandom_range(0, 7) == 0);
      tick();
    end
    clear_fault = 1'b0;

    // Asynchronous reset while faulted
    restart();
    set_in(3'b000, RED, RED, RED); tick();
    tick();
    #3 rst = 1'b0;
    #1 model_reset();
    check_all();
    tick();
    #2 rst = 1'b1;
    set_in(RED, RED, RED, RED);
    repeat (STARTUP_CYCLES) tick();
    light_M1 = GRN; tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_conflict_monitor.md
Name: light_conflict_monitor

Overview:
- Safety stage directly downstream of Traffic_Light_Controller.
- Samples the controller's four 3-bit light codes (M1, M2, MT, S) and drives the lamp outputs from registers.
- Checks every cycle for invalid codes, conflicting greens, skipped yellows and short yellows.
- On any violation, latches a fault and forces all approaches to flashing red until an explicit clear and recovery period.

Parameters:
- MIN_YELLOW, 3: minimum consecutive yellow cycles required before red.
- STARTUP_CYCLES, 5: all-red hold length after reset and during recovery.
- CNT_W, 4: width of the yellow and startup counters. Counters saturate at 2^CNT_W-1. MIN_YELLOW and STARTUP_CYCLES must each be at most 2^CNT_W-1.

Ports:
- clk  in  1  system clock (1 Hz tick in the intersection build).
- rst  in  1  asynchronous, active-low reset.
- light_M1  in  3  controller code, main road direction 1.
- light_M2  in  3  controller code, main road direction 2.
- light_MT  in  3  controller code, main-road turn lane.
- light_S  in  3  controller code, side road.
- clear_fault  in  1  single-cycle request to leave FAULT.
- lamp_M1, lamp_M2, lamp_MT, lamp_S  out  3 each  registered lamp drives.
- fault  out  1  high from fault detection until NORMAL is re-entered.
- fault_code  out  3  0 none, 1 invalid code, 2 conflict, 3 skipped yellow, 4 short yellow.

Behaviour:
- Code encoding: bit2=red, bit1=yellow, bit0=green. Only 3'b100, 3'b010 and 3'b001 are valid. All-red = 3'b100 on every lamp.
- Reset (rst=0, asynchronous):
  - state=STARTUP, all lamps 3'b100, fault=0, fault_code=0.
  - Startup counter=0, yellow counters=0, previous-code registers=3'b100, flash=1.
- STARTUP:
  - Lamps all-red. Previous-code and yellow-counter tracking run; fault checks are disabled.
  - After STARTUP_CYCLES clocks in this state, go to NORMAL.
- NORMAL:
  - Each clock, evaluate the checks on the current inputs.
  - No violation: lamp_X <= light_X, giving one-cycle latency.
  - Violation: on the same edge, lamps <= all-red, fault<=1, fault_code latched, flash<=1, state<=FAULT. A faulty input code never reaches a lamp.
- Checks, per approach X:
  - Invalid (code 1): light_X is not one of the three valid codes.
  - Conflict (code 2):
    - S green or yellow while any of M1/M2/MT is green or yellow.
    - MT green while M2 is green or yellow.
    - M1 and M2 green together is legal.
  - Skipped yellow (code 3): previous code was green and current code is red.
  - Short yellow (code 4): previous code was yellow, current code is red, and yellow count < MIN_YELLOW.
  - Yellow counter: increments (saturating) every cycle light_X is yellow and resets to 0 otherwise. The value compared is the count before the red sample, i.e. the number of yellow cycles seen.
  - Green to yellow, yellow to green and red to green transitions are legal.
  - Simultaneous violations: the lowest fault code wins.
- FAULT:
  - Green and yellow lamp bits are 0. Red bit of every lamp = flash.
  - flash toggles every clock, starting at 1 on entry (red on, off, on, ...).
  - Inputs are ignored except for history tracking.
  - clear_fault=1 at a clock edge goes to RECOVER; lamps all-red on that edge.
  - clear_fault is ignored in every other state.
- RECOVER:
  - Lamps all-red; fault and fault_code held.
  - After STARTUP_CYCLES clocks, go to NORMAL. Clear fault and fault_code on that edge, and apply the NORMAL checks to the sampled inputs on that same edge.
  - A violation on that edge re-enters FAULT immediately.
- Reset mid-operation from any state returns to the reset values asynchronously.

Test Plan:
- Reset then legal sequence: rst low 2 cycles, then all inputs 3'b100 → lamps 3'b100 for 5 cycles. Then M1 sequence 001,001,010,010,010,100 appears on lamp_M1 one cycle later; fault stays 0.
- Short yellow: in NORMAL, light_M2 goes 001, 010, 010, 100 → on the red edge lamps all 3'b100, fault=1, fault_code=4. Red bits then alternate 1, 0, 1, ... each cycle.
- Conflict plus priority: light_S=001 with light_M1=001, and light_MT=3'b011 on the same cycle → fault_code=1 (invalid beats conflict). Repeating with light_MT=3'b100 → fault_code=2.
- Skipped yellow: light_MT goes 001 then 100 → fault_code=3, and lamp_MT never shows 100 from that input path before the fault.
- Clear and recover: in FAULT, pulse clear_fault with all inputs red → lamps all red for 5 cycles, then fault=0, fault_code=0 and inputs pass through. A clear_fault pulse in NORMAL has no effect.
- Async reset in FAULT: assert rst low between clock edges → lamps 3'b100, fault=0 and state STARTUP immediately, without waiting for a clock edge.
